// File: rtl/arith_pkg.sv
// ============================================================================
// arith_pkg : segment map, state encoding and mask helpers for the subtractor
// Revision  : 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

  localparam int NUM_SEGS  = 4;
  localparam int SEG_MAX_W = 18;
  localparam int SEG_LO [NUM_SEGS] = '{0, 1, 4, 14};
  localparam int SEG_HI [NUM_SEGS] = '{0, 3, 13, 31};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEG  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] seg_mask(input logic [1:0] k);
    logic [32:0] span;
    span = (33'h1 << (SEG_HI[k] - SEG_LO[k] + 1)) - 33'h1;
    return span[31:0] << SEG_LO[k];
  endfunction

  // All bits strictly above segment k; empty for the top segment.
  function automatic logic [31:0] above_mask(input logic [1:0] k);
    logic [32:0] below;
    below = (33'h1 << (SEG_HI[k] + 1)) - 33'h1;
    return ~below[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/segment_subtractor.sv
// ============================================================================
// segment_subtractor : combinational a - b - bin for one segment
// Revision           : 1.0
// ============================================================================
`default_nettype none

module segment_subtractor #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             transparent
);

  logic [WIDTH:0] full;

  // The extra top bit goes to 1 exactly when a < b + bin.
  assign full        = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  assign d           = full[WIDTH-1:0];
  assign bout        = full[WIDTH];
  assign transparent = (a == b);

endmodule

`default_nettype wire

// File: rtl/borrow_skip_subtractor.sv
// ============================================================================
// borrow_skip_subtractor : multi-cycle segmented 32-bit subtractor
// Optional early finish on borrow-transparent upper segments: BSS_SKIP_EN
// Revision               : 1.0
// ============================================================================
`default_nettype none

module borrow_skip_subtractor
  import arith_pkg::*;
#(
  parameter int BIT_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] minuend,
  input  logic [BIT_SIZE-1:0] subtrahend,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  state_t              state;
  logic [1:0]          seg_idx;
  logic [BIT_SIZE-1:0] x_reg;
  logic [BIT_SIZE-1:0] y_reg;
  logic                borrow;

  logic [31:0]          mask;
  int unsigned          seg_lo;
  logic [SEG_MAX_W-1:0] seg_a;
  logic [SEG_MAX_W-1:0] seg_b;
  logic [SEG_MAX_W-1:0] seg_d;
  logic                 seg_bout;
  logic                 seg_transparent_unused;
  logic [31:0]          fill;
  logic                 finish;
  logic [31:0]          next_diff;

  assign mask   = seg_mask(seg_idx);
  assign seg_lo = SEG_LO[seg_idx];
  assign seg_a  = SEG_MAX_W'((x_reg & mask) >> seg_lo);
  assign seg_b  = SEG_MAX_W'((y_reg & mask) >> seg_lo);

  segment_subtractor #(
    .WIDTH (SEG_MAX_W)
  ) u_seg (
    .a           (seg_a),
    .b           (seg_b),
    .bin         (borrow),
    .d           (seg_d),
    .bout        (seg_bout),
    .transparent (seg_transparent_unused)
  );

`ifdef BSS_SKIP_EN
  logic [31:0] upper;
  assign upper  = above_mask(seg_idx);
  // Equal upper bits pass the borrow straight through every remaining segment.
  assign finish = ((x_reg ^ y_reg) & upper) == 32'h0;
  assign fill   = seg_bout ? upper : 32'h0;
`else
  assign finish = (seg_idx == 2'd3);
  assign fill   = 32'h0;
`endif

  assign next_diff = (diff & ~mask) | ((32'(seg_d) << seg_lo) & mask) | fill;
  assign in_ready  = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seg_idx    <= 2'd0;
      x_reg      <= '0;
      y_reg      <= '0;
      borrow     <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg   <= minuend;
            y_reg   <= subtrahend;
            borrow  <= 1'b0;
            diff    <= '0;
            seg_idx <= 2'd0;
            state   <= SEG;
          end
        end
        SEG: begin
          diff    <= next_diff;
          borrow  <= seg_bout;
          seg_idx <= seg_idx + 2'd1;
          if (finish) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            borrow_out <= seg_bout;
            overflow   <= (x_reg[BIT_SIZE-1] ^ y_reg[BIT_SIZE-1]) &
                          (next_diff[31] ^ x_reg[BIT_SIZE-1]);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_borrow_skip_subtractor.sv
// ============================================================================
// tb_borrow_skip_subtractor : randomized self-checking bench with arithmetic model
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_borrow_skip_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  borrow_skip_subtractor #(.BIT_SIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int TIMEOUT = 20;

  function automatic logic [31:0] exp_diff(input logic [31:0] x, input logic [31:0] y);
    return x - y;
  endfunction

  function automatic logic exp_ovf(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x - y;
    return (x[31] != y[31]) && (d[31] != x[31]);
  endfunction

  // Latency = 1 + first segment index above which both operands agree.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef BSS_SKIP_EN
    int hi [4] = '{0, 3, 13, 31};
    logic [63:0] xe, ye;
    xe = {32'h0, x};
    ye = {32'h0, y};
    for (int k = 0; k < 4; k++)
      if ((xe >> (hi[k] + 1)) == (ye >> (hi[k] + 1))) return k + 1;
    return 4;
`else
    return 4;
`endif
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] d, output logic b, output logic o,
                        output int lat, output logic busy_after_accept,
                        output logic ready_after);
    @(negedge clk);
    minuend    = x;
    subtrahend = y;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid          = 1'b0;
    busy_after_accept = !in_ready;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = diff;
    b = borrow_out;
    o = overflow;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready   = 1'b0;
    ready_after = in_ready && !out_valid;
  endtask

  task automatic check_op(input string name, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    logic b, o, busy, rdy;
    int lat;
    run_op(x, y, d, b, o, lat, busy, rdy);
    checks++;
    if (d !== exp_diff(x, y)) begin
      errors++;
      $display("FAIL %s diff: got %h expected %h (x=%h y=%h)", name, d, exp_diff(x, y), x, y);
    end
    checks++;
    if (b !== (x < y)) begin
      errors++;
      $display("FAIL %s borrow_out: got %b expected %b (x=%h y=%h)", name, b, (x < y), x, y);
    end
    checks++;
    if (o !== exp_ovf(x, y)) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b (x=%h y=%h)", name, o, exp_ovf(x, y), x, y);
    end
    checks++;
    if (lat !== exp_lat(x, y)) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (x=%h y=%h)", name, lat, exp_lat(x, y), x, y);
    end
    checks++;
    if (busy !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: busy_after_accept=%b ready_after_done=%b expected 1 1", name, busy, rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    minuend = '0; subtrahend = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, diff, borrow_out, overflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h borrow=%b ovf=%b expected 1 0 0 0 0",
               in_ready, out_valid, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    check_op("dir_5_3", 32'd5, 32'd3);
    check_op("dir_0_1", 32'd0, 32'd1);
    check_op("dir_min_1", 32'h8000_0000, 32'd1);
    check_op("dir_equal", 32'h1234_5678, 32'h1234_5678);
    check_op("dir_max_min", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = x ^ ($urandom & 32'h0000_3FFF);
        2: y = x ^ ($urandom & 32'h0000_000F);
        default: y = x;
      endcase
      check_op("random", x, y);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y, d0;
    logic b0, o0;
    int wait_cnt;
    x = 32'h8000_0000;
    y = 32'h0000_0005;
    @(negedge clk);
    minuend = x; subtrahend = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < TIMEOUT) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b expected 1 within %0d cycles", out_valid, TIMEOUT);
    end
    d0 = diff; b0 = borrow_out; o0 = overflow;
    checks++;
    if (d0 !== exp_diff(x, y) || b0 !== (x < y) || o0 !== exp_ovf(x, y)) begin
      errors++;
      $display("FAIL bp_result: diff=%h b=%b o=%b expected %h %b %b",
               d0, b0, o0, exp_diff(x, y), (x < y), exp_ovf(x, y));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      minuend = $urandom; subtrahend = $urandom; in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d0 ||
          borrow_out !== b0 || overflow !== o0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b diff=%h b=%b o=%b expected 1 0 %h %b %b",
                 c, out_valid, in_ready, diff, borrow_out, overflow, d0, b0, o0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    minuend = 32'h8000_0000; subtrahend = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: out_valid=%b diff=%h in_ready=%b expected 0 0 1", out_valid, diff, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset_10_20", 32'd10, 32'd20);
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0};
    logic [31:0] ys [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_3FFF, 32'hDEAD_BEEF, 32'h0};
    for (int i = 0; i < 5; i++) check_op("back_to_back", xs[i], ys[i]);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
